// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the side that drives requests and tx_busy.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 err;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_start, tx_data, err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_start, tx_data, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART byte transmitter.
// state     | meaning
// IDLE      | no owner; pick next requester when transmitter is free
// LOAD      | owner granted; waiting for its next byte
// WAIT_ACK  | tx_start held high until tx_busy rises
// WAIT_DONE | byte on the wire; waiting for tx_busy to fall
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 2047,
  parameter int GAP_TIMEOUT = 4095
) (
  input logic              CLOCK_50,
  input logic              reset_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [AW-1:0]      ack_cnt_q, ack_cnt_d;

  logic [IW-1:0]      winner;
  logic               found;
  logic [IW-1:0]      idx;
  logic [7:0]         sel_data;
  logic [GW-1:0]      gap_inc;
  logic [AW-1:0]      ack_inc;

  // Search order starts just after the last released owner and wraps.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = bus.req_data[7:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IW'(i)) sel_data = bus.req_data[8*i +: 8];
    end
  end

  assign gap_inc = gap_cnt_q + GW'(1);
  assign ack_inc = ack_cnt_q + AW'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    err_d      = 1'b0;
    gap_cnt_d  = gap_cnt_q;
    ack_cnt_d  = ack_cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid && !bus.tx_busy) begin
          grant_d   = ONE << winner;
          owner_d   = winner;
          gap_cnt_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (bus.req_valid[owner_q]) begin
          tx_data_d  = sel_data;
          last_d     = bus.req_last[owner_q];
          tx_start_d = 1'b1;
          gap_cnt_d  = '0;
          ack_cnt_d  = '0;
          state_d    = WAIT_ACK;
        end else begin
          gap_cnt_d = gap_inc;
          if (gap_inc == GW'(GAP_TIMEOUT)) begin
            err_d    = 1'b1;
            grant_d  = '0;
            rr_ptr_d = owner_q;
            state_d  = IDLE;
          end
        end
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end else begin
          ack_cnt_d = ack_inc;
          if (ack_inc == AW'(ACK_TIMEOUT)) begin
            tx_start_d = 1'b0;
            err_d      = 1'b1;
            grant_d    = '0;
            rr_ptr_d   = owner_q;
            state_d    = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          gap_cnt_d = '0;
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = owner_q;
            state_d  = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= IW'(NUM_REQ - 1);
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      gap_cnt_q  <= '0;
      ack_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      err_q      <= err_d;
      gap_cnt_q  <= gap_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
    end
  end

  // Only req_ready is combinational so the owner sees acceptance in its LOAD cycle.
  assign bus.req_ready = (state_q == LOAD && bus.req_valid[owner_q]) ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, reactive transmitter, reference model.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int ACK = 2047;
  localparam int GAP = 4095;

  logic CLOCK_50 = 1'b0;
  logic reset_n;
  always #10 CLOCK_50 = ~CLOCK_50;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(ACK), .GAP_TIMEOUT(GAP)) dut (
    .CLOCK_50(CLOCK_50),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester side: each requester owns a list of {last,byte}; rd_ptr advances on req_ready.
  logic [8:0]   rq[N][$];
  int           rd_ptr[N];
  logic [N-1:0] rdy_seen;

  always begin : requesters
    logic [N-1:0]   v, l;
    logic [8*N-1:0] d;
    logic [8:0]     e;
    @(posedge CLOCK_50);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rdy_seen[i] === 1'b1 && rd_ptr[i] < rq[i].size()) rd_ptr[i]++;
      if (rd_ptr[i] < rq[i].size()) begin
        e = rq[i][rd_ptr[i]];
        v[i] = 1'b1; d[8*i +: 8] = e[7:0]; l[i] = e[8];
      end else begin
        v[i] = 1'b0; d[8*i +: 8] = 8'h00; l[i] = 1'b0;
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
  end

  // Transmitter: busy 3 cycles after seeing tx_start, busy for busy_len cycles; tx_mode=0 never acks.
  bit tx_mode  = 1'b1;
  int busy_len = 20;
  int tx_phase = 0;
  int tx_cnt   = 0;

  always begin : transmitter
    @(posedge CLOCK_50);
    #1;
    if (reset_n !== 1'b1) begin
      bus.tx_busy = 1'b0; tx_phase = 0; tx_cnt = 0;
    end else begin
      case (tx_phase)
        0: if (bus.tx_start && tx_mode) begin
             tx_cnt++;
             if (tx_cnt >= 3) begin bus.tx_busy = 1'b1; tx_phase = 1; tx_cnt = 0; end
           end
        1: begin
             tx_cnt++;
             if (tx_cnt >= busy_len) begin bus.tx_busy = 1'b0; tx_phase = 2; tx_cnt = 0; end
           end
        default: if (!bus.tx_start) tx_phase = 0;
      endcase
    end
  end

  // Reference model: owner (-1 = none), whether a byte is being offered or on the wire,
  // plus elapsed-cycle tallies for the two timeouts.
  int         m_owner, m_rr, m_gap, m_ack;
  bit         m_start, m_flight, m_last, m_err;
  logic [7:0] m_data;

  always @(posedge CLOCK_50 or negedge reset_n) begin : model
    logic [N-1:0] rv;
    bit           hit;
    int           j;
    if (!reset_n) begin
      m_owner = -1; m_rr = N - 1; m_gap = 0; m_ack = 0;
      m_start = 0; m_flight = 0; m_last = 0; m_err = 0; m_data = 8'h00;
    end else begin
      rv    = bus.req_valid;
      m_err = 0;
      if (m_owner < 0) begin
        if (rv != 0 && !bus.tx_busy) begin
          hit = 0;
          for (int k = 1; k <= N; k++) begin
            j = (m_rr + k) % N;
            if (!hit && rv[j]) begin m_owner = j; hit = 1; end
          end
          m_gap = 0;
        end
      end else if (m_start) begin
        if (bus.tx_busy) begin
          m_start = 0; m_flight = 1;
        end else begin
          m_ack++;
          if (m_ack == ACK) begin m_start = 0; m_err = 1; m_rr = m_owner; m_owner = -1; end
        end
      end else if (m_flight) begin
        if (!bus.tx_busy) begin
          m_flight = 0;
          if (m_last) begin m_rr = m_owner; m_owner = -1; end
          else m_gap = 0;
        end
      end else if (rv[m_owner]) begin
        m_data  = bus.req_data[8*m_owner +: 8];
        m_last  = bus.req_last[m_owner];
        m_start = 1; m_ack = 0; m_gap = 0;
      end else begin
        m_gap++;
        if (m_gap == GAP) begin m_err = 1; m_rr = m_owner; m_owner = -1; end
      end
    end
  end

  int           acc_idx[$];
  logic [7:0]   acc_data[$];
  logic [N-1:0] acc_grant[$];

  always @(negedge CLOCK_50) begin : compare
    logic [N-1:0] exp_grant, exp_rdy;
    rdy_seen = bus.req_ready;
    if (reset_n === 1'b1) begin
      exp_grant = '0;
      exp_rdy   = '0;
      if (m_owner >= 0) begin
        exp_grant[m_owner] = 1'b1;
        if (!m_start && !m_flight && bus.req_valid[m_owner]) exp_rdy[m_owner] = 1'b1;
      end
      chk("grant",     32'(bus.grant),     32'(exp_grant));
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("tx_start",  32'(bus.tx_start),  32'(m_start));
      chk("tx_data",   32'(bus.tx_data),   32'(m_data));
      chk("err",       32'(bus.err),       32'(m_err));
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i]) begin
          acc_idx.push_back(i);
          acc_data.push_back(bus.req_data[8*i +: 8]);
          acc_grant.push_back(bus.grant);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (rd_ptr[i] < rq[i].size()) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(drained() && bus.grant == 0 && !bus.tx_start && !bus.tx_busy) && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_sig(input string name, input int budget, input int which, input bit val);
    int n = 0;
    bit s;
    forever begin
      s = (which == 0) ? bus.tx_busy : (which == 1) ? bus.err : (bus.tx_busy && !bus.tx_start);
      if (s == val || n >= budget) break;
      @(negedge CLOCK_50);
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, n, cnt;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_grant",     32'(bus.grant),     32'h0);
    chk("rst_tx_start",  32'(bus.tx_start),  32'h0);
    chk("rst_tx_data",   32'(bus.tx_data),   32'h00);
    chk("rst_err",       32'(bus.err),       32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;

    // 1: single byte, latency and handshake
    base = acc_idx.size();
    rq[0].push_back({1'b1, 8'h41});
    n = 0;
    while (!bus.req_ready[0] && n < 10) begin @(negedge CLOCK_50); n++; end
    chk("t1_latency", 32'(n), 32'd2);
    @(negedge CLOCK_50);
    chk("t1_tx_start", 32'(bus.tx_start), 32'd1);
    chk("t1_tx_data",  32'(bus.tx_data),  32'h41);
    wait_idle("t1_idle", 200);
    chk("t1_ready_count", 32'(acc_idx.size() - base), 32'd1);
    chk("t1_grant_end",   32'(bus.grant), 32'h0);

    // 2: round robin order and wrap
    do_reset();
    base = acc_idx.size();
    for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'h10 + 8'(i)});
    wait_idle("t2_idle_a", 600);
    rq[0].push_back({1'b1, 8'h20});
    wait_idle("t2_idle_b", 200);
    chk("t2_count", 32'(acc_idx.size() - base), 32'd5);
    for (int i = 0; i < 5 && base + i < acc_idx.size(); i++) begin
      chk($sformatf("t2_order%0d", i), 32'(acc_idx[base+i]), (i == 4) ? 32'd0 : 32'(i));
      chk($sformatf("t2_data%0d", i), 32'(acc_data[base+i]), (i == 4) ? 32'h20 : 32'h10 + 32'(i));
    end

    // 3: multi-byte message is not interleaved
    do_reset();
    base = acc_idx.size();
    rq[1].push_back({1'b0, 8'h30});
    rq[1].push_back({1'b0, 8'h31});
    rq[1].push_back({1'b1, 8'h32});
    rq[2].push_back({1'b1, 8'h40});
    wait_idle("t3_idle", 600);
    chk("t3_count", 32'(acc_idx.size() - base), 32'd4);
    if (acc_idx.size() - base == 4) begin
      chk("t3_b0",     32'(acc_data[base]),   32'h30);
      chk("t3_b1",     32'(acc_data[base+1]), 32'h31);
      chk("t3_b2",     32'(acc_data[base+2]), 32'h32);
      chk("t3_b3",     32'(acc_data[base+3]), 32'h40);
      chk("t3_grant3", 32'(acc_grant[base+3]), 32'h4);
    end

    // 4: transmitter never acknowledges
    do_reset();
    base = acc_idx.size();
    tx_mode = 1'b0;
    rq[0].push_back({1'b1, 8'hAA});
    rq[1].push_back({1'b1, 8'hBB});
    cnt = 0; n = 0;
    while (!bus.err && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
      if (bus.tx_start) cnt++;
    end
    tx_mode = 1'b1;
    chk("t4_err_seen",     32'(bus.err),      32'd1);
    chk("t4_start_cycles", 32'(cnt),          32'(ACK));
    chk("t4_grant_rel",    32'(bus.grant),    32'h0);
    chk("t4_start_low",    32'(bus.tx_start), 32'h0);
    wait_idle("t4_idle", 200);
    chk("t4_count", 32'(acc_idx.size() - base), 32'd2);
    if (acc_idx.size() - base == 2) chk("t4_next", 32'(acc_idx[base+1]), 32'd1);

    // 5: owner stalls mid-message
    do_reset();
    base = acc_idx.size();
    rq[2].push_back({1'b0, 8'h50});
    wait_sig("t5_busy_hi", 100, 0, 1'b1);
    wait_sig("t5_busy_lo", 100, 0, 1'b0);
    n = 0;
    while (!bus.err && n < GAP + 100) begin @(negedge CLOCK_50); n++; end
    chk("t5_gap_cycles", 32'(n), 32'(GAP + 1));
    chk("t5_grant_rel",  32'(bus.grant), 32'h0);
    rq[3].push_back({1'b1, 8'h60});
    rq[0].push_back({1'b1, 8'h61});
    wait_idle("t5_idle", 300);
    chk("t5_count", 32'(acc_idx.size() - base), 32'd3);
    if (acc_idx.size() - base == 3) begin
      chk("t5_rr_next", 32'(acc_idx[base+1]), 32'd3);
      chk("t5_rr_wrap", 32'(acc_idx[base+2]), 32'd0);
    end

    // 6: reset while a byte is on the wire
    do_reset();
    busy_len = 200;
    rq[0].push_back({1'b1, 8'h77});
    wait_sig("t6_wait_done", 100, 2, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_tx_start",  32'(bus.tx_start),  32'h0);
    chk("t6_grant",     32'(bus.grant),     32'h0);
    chk("t6_req_ready", 32'(bus.req_ready), 32'h0);
    chk("t6_tx_data",   32'(bus.tx_data),   32'h00);
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    busy_len = 20;
    repeat (20) @(negedge CLOCK_50);
    chk("t6_still_idle", 32'(bus.grant), 32'h0);
    base = acc_idx.size();
    rq[1].push_back({1'b1, 8'h78});
    wait_idle("t6_idle", 200);
    chk("t6_count", 32'(acc_idx.size() - base), 32'd1);
    if (acc_idx.size() - base == 1) chk("t6_data", 32'(acc_data[base]), 32'h78);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
